decoder_scan_n: RTL and testbench
=================================

Name: decoder_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. Successor to the fixed 2-to-4 gate-level decoder.
- Two modes:
  - Direct: decode an address accepted through a valid/ready handshake.
  - Scan: autonomously step through every output with a programmable dwell, as a row/select scanner.
- Sits between control logic and select lines: memory rows, display digits, mux enables.

Parameters:
- ADDR_W, 2, address width; output width is 2**ADDR_W (legal 1..6).
- DWELL_W, 4, width of the dwell-count input.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  output enable; low forces dout to zero.
- mode  in  1  0 = direct, 1 = scan; sampled only on accept/start.
- addr_in  in  ADDR_W  direct-mode address.
- addr_valid  in  1  addr_in is valid.
- addr_ready  out  1  block can accept an address.
- start  in  1  single-cycle pulse that begins a scan.
- stop  in  1  single-cycle pulse that ends a scan.
- dwell  in  DWELL_W  cycles-per-output minus 1; sampled at start.
- dout  out  2**ADDR_W  registered one-hot output.
- cur_addr  out  ADDR_W  address currently decoded.
- busy  out  1  high while in SCAN.
- wrap_pulse  out  1  one-cycle pulse when the scan wraps to its first address.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - dout=0, cur_addr=0, busy=0, wrap_pulse=0.
  - State IDLE, dwell counter 0.
  - addr_ready=1 once rst_n releases.
- States:
  - IDLE: dout=0.
  - HOLD: static one-hot output.
  - SCAN: stepping.
- addr_ready is combinational: (state != SCAN) && !start.
- Direct accept:
  - Occurs when addr_valid && addr_ready && mode==0, in IDLE or HOLD.
  - Next edge: cur_addr=addr_in; dout=onehot(addr_in) if en, else 0; state HOLD.
  - Latency is exactly 1 cycle. Back-to-back accepts are allowed every cycle.
- addr_valid with mode==1: no handshake completes; the address is dropped and state is unchanged.
- Scan start:
  - start && mode==1 in IDLE or HOLD.
  - Next edge: cur_addr = first sequence address (0); dout=onehot(first); dwell counter = dwell; busy=1; state SCAN.
  - start has priority over a simultaneous addr_valid, which is not accepted.
- SCAN stepping:
  - The counter decrements each cycle. At 0, cur_addr advances to the next sequence address and the counter reloads the dwell value latched at start.
  - Each output is therefore held dwell+1 cycles. dwell=0 advances every cycle.
- Wrap:
  - The step from the last sequence address to the first asserts wrap_pulse for exactly one cycle, aligned with the dout update.
  - wrap_pulse is never asserted outside SCAN.
- stop in SCAN:
  - Next edge: state HOLD, busy=0; cur_addr and dout frozen at the current value.
  - stop beats a coincident step: no advance and no wrap_pulse.
- Ignored inputs:
  - start in SCAN is ignored; stop outside SCAN is ignored.
  - start and stop in the same SCAN cycle: stop wins.
- en low:
  - dout registers to 0 at the next edge.
  - State, cur_addr and the dwell counter keep running or holding normally.
  - Re-asserting en restores onehot(cur_addr) at the next edge.
- mode changes in SCAN have no effect until the block returns to HOLD.
- Reset asserted mid-scan: immediate return to reset values, with no glitch pulse on wrap_pulse.
- dout is always either zero or exactly one-hot; never multi-hot.

Optional Feature:
- Macro: DECODER_SCAN_GRAY_EN.
- Defined:
  - Scan order is binary-reflected Gray code: seq index i maps to address i ^ (i>>1).
  - Successive outputs differ in one cur_addr bit; wrap occurs from address 2**(ADDR_W-1) back to 0.
- Undefined:
  - Plain binary increment 0..2**ADDR_W-1; wrap occurs from all-ones to 0.
  - No Gray logic is synthesised.
- Direct mode is identical either way.

Decomposition:
- Package decoder_scan_pkg:
  - State enum (IDLE, HOLD, SCAN).
  - Function onehot(addr) and function bin2gray(idx).
  - Mode constants MODE_DIRECT=0, MODE_SCAN=1.
- Sub-module onehot_dec: combinational ADDR_W-to-2**ADDR_W decoder with enable, instantiated once ahead of the dout register.

Test Plan (ADDR_W=2, DWELL_W=4):
- Reset, then direct accept addr_in=2 with en=1 → next cycle dout=4'b0100, cur_addr=2; addr_ready stays 1; back-to-back addresses 0,3 → dout 0001 then 1000.
- Scan with dwell=2, binary → dout 0001 held 3 cycles, then 0010, 0100, 1000; wrap_pulse for one cycle when dout returns to 0001; busy=1 throughout.
- stop while dout=0100 with the dwell counter at 0 → no advance; dout stays 0100; busy=0; state HOLD; a subsequent direct accept of addr 1 gives 0010.
- en dropped for 3 cycles during a dwell=0 scan → dout=0 during those cycles while cur_addr continues 1,2,3; en restored → dout=onehot(cur_addr) next edge.
- start and addr_valid together in IDLE → addr_ready=0, scan begins at 0001, address not taken; start+stop together in SCAN → stop wins.
- With DECODER_SCAN_GRAY_EN and dwell=0 → cur_addr sequence 0,1,3,2,0; wrap_pulse on 2→0; reset mid-scan → all outputs 0 asynchronously.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder_scan_n slice.
// Optional build macro: DECODER_SCAN_GRAY_EN selects the Gray-code scan order.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest supported address; helpers work at this width and callers truncate.
  localparam int MAX_ADDR_W = 6;

  function automatic logic [(1<<MAX_ADDR_W)-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr);
    logic [(1<<MAX_ADDR_W)-1:0] r;
    r       = '0;
    r[addr] = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] bin2gray(input logic [MAX_ADDR_W-1:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational ADDR_W-to-2**ADDR_W one-hot decoder with enable.
module onehot_dec
  import decoder_scan_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(1<<ADDR_W)-1:0]   dec
);

  localparam int OUT_W = 1 << ADDR_W;

  // Disabled decoder yields all zeros, never a partial pattern.
  assign dec = en ? OUT_W'(onehot(MAX_ADDR_W'(addr))) : '0;

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2**N one-hot decoder with direct (handshake) and scan modes.
// Build macro DECODER_SCAN_GRAY_EN: scan steps in binary-reflected Gray order
// instead of plain binary. Direct mode is unaffected by the macro.
module decoder_scan_n
  import decoder_scan_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int DWELL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [ADDR_W-1:0]       addr_in,
  input  logic                    addr_valid,
  output logic                    addr_ready,
  input  logic                    start,
  input  logic                    stop,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(1<<ADDR_W)-1:0]  dout,
  output logic [ADDR_W-1:0]       cur_addr,
  output logic                    busy,
  output logic                    wrap_pulse
);

  localparam int                OUT_W    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  state_t               state, nxt_state;
  logic [ADDR_W-1:0]    seq_idx, nxt_idx, idx_inc;
  logic [ADDR_W-1:0]    nxt_addr;
  logic [DWELL_W-1:0]   dwell_cnt, nxt_cnt;
  logic [DWELL_W-1:0]   dwell_lat, nxt_dwell;
  logic                 nxt_wrap;
  logic                 dec_en;
  logic [OUT_W-1:0]     dec;

  // Sequence index to output address; the index always counts in binary.
  function automatic logic [ADDR_W-1:0] seq2addr(input logic [ADDR_W-1:0] i);
`ifdef DECODER_SCAN_GRAY_EN
    return ADDR_W'(bin2gray(MAX_ADDR_W'(i)));
`else
    return i;
`endif
  endfunction

  // start blocks the handshake so it wins over a coincident address.
  assign addr_ready = (state != SCAN) && !start;
  assign idx_inc    = seq_idx + 1'b1;

  // Next-state, next-address and dwell counter decisions for this cycle.
  always_comb begin
    nxt_state = state;
    nxt_idx   = seq_idx;
    nxt_addr  = cur_addr;
    nxt_cnt   = dwell_cnt;
    nxt_dwell = dwell_lat;
    nxt_wrap  = 1'b0;
    case (state)
      SCAN: begin
        if (stop) begin
          // Stop freezes the current output, even on a step cycle.
          nxt_state = HOLD;
        end else if (dwell_cnt == '0) begin
          nxt_idx  = idx_inc;
          nxt_addr = seq2addr(idx_inc);
          nxt_cnt  = dwell_lat;
          nxt_wrap = (seq_idx == LAST_IDX);
        end else begin
          nxt_cnt = dwell_cnt - 1'b1;
        end
      end
      default: begin
        if (start && mode == MODE_SCAN) begin
          nxt_state = SCAN;
          nxt_idx   = '0;
          nxt_addr  = seq2addr('0);
          nxt_cnt   = dwell;
          nxt_dwell = dwell;
        end else if (addr_valid && addr_ready && mode == MODE_DIRECT) begin
          nxt_state = HOLD;
          nxt_addr  = addr_in;
        end
      end
    endcase
  end

  // IDLE never drives a select line; otherwise en gates the decoded address.
  assign dec_en = en && (nxt_state != IDLE);

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
    .en   (dec_en),
    .addr (nxt_addr),
    .dec  (dec)
  );

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      seq_idx    <= '0;
      cur_addr   <= '0;
      dwell_cnt  <= '0;
      dwell_lat  <= '0;
      dout       <= '0;
      busy       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= nxt_state;
      seq_idx    <= nxt_idx;
      cur_addr   <= nxt_addr;
      dwell_cnt  <= nxt_cnt;
      dwell_lat  <= nxt_dwell;
      dout       <= dec;
      busy       <= (nxt_state == SCAN);
      wrap_pulse <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Self-checking bench for decoder_scan_n (ADDR_W=2, DWELL_W=4), scoreboard style.
module tb_decoder_scan_n;

  localparam int ADDR_W  = 2;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n, en, mode, addr_valid, start, stop;
  logic [ADDR_W-1:0]  addr_in;
  logic [DWELL_W-1:0] dwell;
  logic               addr_ready, busy, wrap_pulse;
  logic [3:0]         dout;
  logic [ADDR_W-1:0]  cur_addr;

  typedef struct {
    logic [3:0] d;
    logic [1:0] a;
    logic       b;
    logic       w;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  decoder_scan_n #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .addr_in    (addr_in),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .start      (start),
    .stop       (stop),
    .dwell      (dwell),
    .dout       (dout),
    .cur_addr   (cur_addr),
    .busy       (busy),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  // Expected scan address for sequence step i.
  function automatic logic [1:0] seq_addr(input int i);
    logic [1:0] x;
    x = 2'(i % 4);
`ifdef DECODER_SCAN_GRAY_EN
    return x ^ (x >> 1);
`else
    return x;
`endif
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] a);
    logic [3:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

  function automatic exp_t mk(input logic [3:0] d, input logic [1:0] a, input logic b, input logic w);
    exp_t x;
    x.d = d; x.a = a; x.b = b; x.w = w;
    return x;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; addr_valid = 1'b0; start = 1'b0;
    stop = 1'b0; addr_in = '0; dwell = '0;
    #3;
    sbq.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
    e = sbq.pop_front(); n_chk++;
    if ({dout, cur_addr, busy, wrap_pulse} !== {e.d, e.a, e.b, e.w}) begin
      n_fail++;
      $display("FAIL reset: dout=%b cur_addr=%0d busy=%b wrap=%b, expected %b %0d %b %b",
               dout, cur_addr, busy, wrap_pulse, e.d, e.a, e.b, e.w);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_chk++;
    if (addr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: addr_ready=%b, expected 1", addr_ready);
    end
  endtask

  task automatic test_direct();
    logic [1:0] seq [4] = '{2'd2, 2'd0, 2'd3, 2'd3};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mode = 1'b0; addr_valid = (k < 3); addr_in = seq[k];
      sbq.push_back(mk(oh(seq[k]), seq[k], 1'b0, 1'b0));
      #1; n_chk++;
      if (addr_ready !== 1'b1) begin
        n_fail++; $display("FAIL direct_ready[%0d]: addr_ready=%b, expected 1", k, addr_ready);
      end
      @(posedge clk); #1;
      e = sbq.pop_front(); n_chk++;
      if ({dout, cur_addr, busy, wrap_pulse} !== {e.d, e.a, e.b, e.w}) begin
        n_fail++;
        $display("FAIL direct[%0d]: dout=%b cur_addr=%0d busy=%b wrap=%b, expected %b %0d %b %b",
                 k, dout, cur_addr, busy, wrap_pulse, e.d, e.a, e.b, e.w);
      end
    end
  endtask

  // dwell=2 scan through one full wrap, then stop on a step cycle, then a direct accept.
  task automatic test_scan_stop();
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      start = (k == 0); mode = 1'b1; dwell = (k == 0) ? 4'd2 : 4'd9;
      stop = (k == 21); addr_valid = (k == 22); addr_in = 2'd1;
      if (k == 22) mode = 1'b0;
      if (k < 21)       sbq.push_back(mk(oh(seq_addr(k/3)), seq_addr(k/3), 1'b1, k == 12));
      else if (k == 21) sbq.push_back(mk(oh(seq_addr(2)), seq_addr(2), 1'b0, 1'b0));
      else              sbq.push_back(mk(4'b0010, 2'd1, 1'b0, 1'b0));
      if (k == 5) begin
        #1; n_chk++;
        if (addr_ready !== 1'b0) begin
          n_fail++; $display("FAIL scan_ready: addr_ready=%b, expected 0", addr_ready);
        end
      end
      @(posedge clk); #1;
      e = sbq.pop_front(); n_chk++;
      if ({dout, cur_addr, busy, wrap_pulse} !== {e.d, e.a, e.b, e.w}) begin
        n_fail++;
        $display("FAIL scan_stop[%0d]: dout=%b cur_addr=%0d busy=%b wrap=%b, expected %b %0d %b %b",
                 k, dout, cur_addr, busy, wrap_pulse, e.d, e.a, e.b, e.w);
      end
    end
    addr_valid = 1'b0; stop = 1'b0;
  endtask

  task automatic test_en_drop();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = (k == 0); mode = 1'b1; dwell = 4'd0; stop = (k == 5);
      en = !(k >= 1 && k <= 3);
      if (k == 0)      sbq.push_back(mk(oh(seq_addr(0)), seq_addr(0), 1'b1, 1'b0));
      else if (k <= 3) sbq.push_back(mk(4'b0000, seq_addr(k), 1'b1, 1'b0));
      else if (k == 4) sbq.push_back(mk(oh(seq_addr(0)), seq_addr(0), 1'b1, 1'b1));
      else             sbq.push_back(mk(oh(seq_addr(0)), seq_addr(0), 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sbq.pop_front(); n_chk++;
      if ({dout, cur_addr, busy, wrap_pulse} !== {e.d, e.a, e.b, e.w}) begin
        n_fail++;
        $display("FAIL en_drop[%0d]: dout=%b cur_addr=%0d busy=%b wrap=%b, expected %b %0d %b %b",
                 k, dout, cur_addr, busy, wrap_pulse, e.d, e.a, e.b, e.w);
      end
    end
    stop = 1'b0; en = 1'b1;
  endtask

  // start beats addr_valid in IDLE; stop beats start in SCAN; mode=1 address is dropped.
  task automatic test_priority();
    @(negedge clk); rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mode = 1'b1; dwell = 4'd0; addr_in = 2'd3;
      start = (k <= 1); stop = (k == 1); addr_valid = (k == 0 || k == 2);
      if (k == 0) begin
        sbq.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0));
        #1; n_chk++;
        if (addr_ready !== 1'b0) begin
          n_fail++; $display("FAIL start_ready: addr_ready=%b, expected 0", addr_ready);
        end
      end else begin
        sbq.push_back(mk(4'b0001, 2'd0, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      e = sbq.pop_front(); n_chk++;
      if ({dout, cur_addr, busy, wrap_pulse} !== {e.d, e.a, e.b, e.w}) begin
        n_fail++;
        $display("FAIL priority[%0d]: dout=%b cur_addr=%0d busy=%b wrap=%b, expected %b %0d %b %b",
                 k, dout, cur_addr, busy, wrap_pulse, e.d, e.a, e.b, e.w);
      end
    end
    start = 1'b0; addr_valid = 1'b0;
  endtask

`ifdef DECODER_SCAN_GRAY_EN
  task automatic test_gray();
    logic [1:0] ga [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = (k == 0); mode = 1'b1; dwell = 4'd0; stop = (k == 5);
      if (k < 5) sbq.push_back(mk(oh(ga[k]), ga[k], 1'b1, k == 4));
      else       sbq.push_back(mk(4'b0001, 2'd0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sbq.pop_front(); n_chk++;
      if ({dout, cur_addr, busy, wrap_pulse} !== {e.d, e.a, e.b, e.w}) begin
        n_fail++;
        $display("FAIL gray[%0d]: dout=%b cur_addr=%0d busy=%b wrap=%b, expected %b %0d %b %b",
                 k, dout, cur_addr, busy, wrap_pulse, e.d, e.a, e.b, e.w);
      end
    end
    stop = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = (k == 0); mode = 1'b1; dwell = 4'd1;
      sbq.push_back(mk(oh(seq_addr(k/2)), seq_addr(k/2), 1'b1, 1'b0));
      @(posedge clk); #1;
      e = sbq.pop_front(); n_chk++;
      if ({dout, cur_addr, busy, wrap_pulse} !== {e.d, e.a, e.b, e.w}) begin
        n_fail++;
        $display("FAIL reset_mid_run[%0d]: dout=%b cur_addr=%0d busy=%b wrap=%b, expected %b %0d %b %b",
                 k, dout, cur_addr, busy, wrap_pulse, e.d, e.a, e.b, e.w);
      end
    end
    start = 1'b0;
    @(negedge clk); #2; rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sbq.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
      if (k == 0) #1;
      else begin @(posedge clk); #1; end
      e = sbq.pop_front(); n_chk++;
      if ({dout, cur_addr, busy, wrap_pulse} !== {e.d, e.a, e.b, e.w}) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: dout=%b cur_addr=%0d busy=%b wrap=%b, expected %b %0d %b %b",
                 k, dout, cur_addr, busy, wrap_pulse, e.d, e.a, e.b, e.w);
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_stop();
    test_en_drop();
    test_priority();
`ifdef DECODER_SCAN_GRAY_EN
    test_gray();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
